// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the iterative multiply/divide unit.
//   - RISC-V M-extension funct3 encodings (MDU_MUL .. MDU_REMU)
//   - FSM state encodings (MDU_IDLE/MDU_CALC/MDU_FIX/MDU_DONE)
//   - default operand width
//   - helpers classifying which operands an op treats as signed
package mdu_pkg;

  localparam int MDU_XLEN_DEFAULT = 32;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  localparam logic [1:0] MDU_IDLE = 2'd0;
  localparam logic [1:0] MDU_CALC = 2'd1;
  localparam logic [1:0] MDU_FIX  = 2'd2;
  localparam logic [1:0] MDU_DONE = 2'd3;

  // rs1 is signed for MUL/MULH/MULHSU/DIV/REM.
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
           (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  // rs2 is signed for MUL/MULH/DIV/REM (MULHSU treats it as unsigned).
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MDU_MUL) || (op == MDU_MULH) ||
           (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step.
// Shifts remainder:quotient left by one, trial-subtracts the divisor from
// the shifted remainder, keeps the difference when it is non-negative and
// shifts the resulting quotient bit into the quotient LSB.
// Ports:
//   i_rem  [XLEN]  partial remainder (always < divisor)
//   i_quot [XLEN]  dividend bits still to consume / quotient bits so far
//   i_div  [XLEN]  divisor magnitude
//   o_rem  [XLEN]  next partial remainder
//   o_quot [XLEN]  next quotient word
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quot,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quot
);

  logic [XLEN:0]   w_shifted;
  logic [XLEN+1:0] w_diff;
  logic            w_ge;

  assign w_shifted = {i_rem, i_quot[XLEN-1]};
  // One extra bit so the MSB of the difference is a clean borrow flag.
  assign w_diff    = {1'b0, w_shifted} - {2'b00, i_div};
  assign w_ge      = ~w_diff[XLEN+1];

  // Either branch is below the divisor, so it fits in XLEN bits.
  assign o_rem  = w_ge ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];
  assign o_quot = {i_quot[XLEN-2:0], w_ge};

endmodule

// File: rtl/mdu.sv
// mdu: iterative RISC-V M-extension multiply/divide unit.
// Multiplies use radix-2 shift-add, divides use restoring division; both
// share one 2*XLEN accumulator, one counter and one FSM.
// Optional feature macro: MDU_FAST_MUL_EN -- when defined, multiplies use a
// single-cycle signed-extended product and go IDLE->FIX->DONE.
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    request handshake (in_ready high only in IDLE)
//   in_op [3]            funct3 (MUL..REMU)
//   in_a, in_b [XLEN]    rs1, rs2
//   kill                 flush: abort any in-flight or held operation
//   out_valid/out_ready  result handshake
//   out_result [XLEN]    registered result
//   dbg_state [2]        current FSM state
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN_DEFAULT,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [1:0]      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high. A request is taken only in IDLE with kill low; a result
  // is held stable in DONE until out_ready, and the unit goes back to IDLE
  // the following cycle, so no request is taken in the retiring cycle.

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [2:0]        r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg;
  logic [2*XLEN-1:0] r_acc;    // mul: product:multiplier, div: rem:quot
  logic [XLEN-1:0]   r_mcand;  // multiplicand or divisor magnitude
  logic [XLEN-1:0]   r_result;
  logic              r_valid;

  // Request decode (IDLE only)
  logic            w_accept;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_is_rem;
  logic            w_res_neg;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_short;
  logic [XLEN-1:0] w_short_res;

  assign w_accept   = in_valid && (r_state == MDU_IDLE) && !kill;
  assign w_a_neg    = op_a_signed(in_op) && in_a[XLEN-1];
  assign w_b_neg    = op_b_signed(in_op) && in_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -in_a : in_a;
  assign w_b_mag    = w_b_neg ? -in_b : in_b;
  assign w_is_rem   = in_op[2] && in_op[1];
  // Remainder takes the dividend's sign; products/quotients take a^b.
  // w_b_neg is already 0 whenever b is unsigned (MULHSU, unsigned ops).
  assign w_res_neg  = w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_div_zero = in_op[2] && (in_b == '0);
  assign w_ovf      = ((in_op == MDU_DIV) || (in_op == MDU_REM)) &&
                      (in_a == INT_MIN) && (in_b == '1);
  assign w_short    = w_div_zero || w_ovf;

  always_comb begin
    w_short_res = '0;
    if (w_div_zero) begin
      w_short_res = w_is_rem ? in_a : '1;
    end else if (w_ovf) begin
      w_short_res = w_is_rem ? '0 : in_a;
    end
  end

`ifdef MDU_FAST_MUL_EN
  // Sign-extend each operand by one bit so MULHSU/MULHU share one signed
  // multiplier; the low 2*XLEN bits are the exact product.
  logic signed [2*XLEN+1:0] w_fa;
  logic signed [2*XLEN+1:0] w_fb;
  logic signed [2*XLEN+1:0] w_fast_full;
  assign w_fa = signed'({{(XLEN+1){op_a_signed(in_op) & in_a[XLEN-1]}}, in_a});
  assign w_fb = signed'({{(XLEN+1){op_b_signed(in_op) & in_b[XLEN-1]}}, in_b});
  assign w_fast_full = w_fa * w_fb;
`endif

  // Shift-add multiply step: add multiplicand into the high half when the
  // multiplier LSB is set, then shift the whole accumulator right by one.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                      (r_acc[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  logic [XLEN-1:0] w_div_rem;
  logic [XLEN-1:0] w_div_quot;
  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .i_rem  (r_acc[2*XLEN-1:XLEN]),
    .i_quot (r_acc[XLEN-1:0]),
    .i_div  (r_mcand),
    .o_rem  (w_div_rem),
    .o_quot (w_div_quot)
  );

  // FIX: sign correction and result selection.
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      MDU_MUL:                        w_fix_res = w_prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:              w_fix_res = w_quo;
      default:                        w_fix_res = w_rem;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MDU_IDLE: begin
        if (w_accept) begin
          if (w_short) begin
            w_state_nxt = MDU_DONE;
          end else begin
`ifdef MDU_FAST_MUL_EN
            w_state_nxt = in_op[2] ? MDU_CALC : MDU_FIX;
`else
            w_state_nxt = MDU_CALC;
`endif
          end
        end
      end
      MDU_CALC: if (r_cnt == CNT_W'(1)) w_state_nxt = MDU_FIX;
      MDU_FIX:  w_state_nxt = MDU_DONE;
      default:  if (out_ready) w_state_nxt = MDU_IDLE;
    endcase
    if (kill) w_state_nxt = MDU_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= MDU_IDLE;
      r_op     <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == MDU_DONE);
      case (r_state)
        MDU_IDLE: begin
          if (w_accept) begin
            r_op    <= in_op;
            r_neg   <= w_res_neg;
            r_cnt   <= CNT_W'(XLEN);
            r_mcand <= w_b_mag;
            r_acc   <= {{XLEN{1'b0}}, w_a_mag};
`ifdef MDU_FAST_MUL_EN
            if (!in_op[2]) begin
              r_acc <= w_fast_full[2*XLEN-1:0];
              r_neg <= 1'b0;
            end
`endif
            if (w_short) r_result <= w_short_res;
          end
        end
        MDU_CALC: begin
          r_acc <= r_op[2] ? {w_div_rem, w_div_quot} : w_mul_next;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        MDU_FIX: if (!kill) r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == MDU_IDLE);
  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
  localparam int XLEN = 32;
  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
  localparam logic [XLEN-1:0] MIN_INT = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [1:0]      dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [XLEN-1:0] exp_q[$];

  mdu #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .kill       (kill),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_mdu(input logic [2:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    r  = 0;
    case (op)
      OP_MUL:    begin r = sa * sb; return r[31:0]; end
      OP_MULH:   begin r = sa * sb; return r[63:32]; end
      OP_MULHSU: begin r = sa * ub; return r[63:32]; end
      OP_MULHU:  begin r = ua * ub; return r[63:32]; end
      OP_DIV: begin
        if (b == 0) return '1;
        if (a == MIN_INT && b == '1) return a;
        r = sa / sb; return r[31:0];
      end
      OP_DIVU: begin
        if (b == 0) return '1;
        r = ua / ub; return r[31:0];
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == '1) return '0;
        r = sa % sb; return r[31:0];
      end
      default: begin
        if (b == 0) return a;
        r = ua % ub; return r[31:0];
      end
    endcase
  endfunction

  // Cycles from driving the request (just after an edge) to out_valid seen.
  function automatic int exp_lat(input logic [2:0] op, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    if (op[2] && (b == 0 || ((op == OP_DIV || op == OP_REM) && a == MIN_INT && b == '1)))
      return 1;
`ifdef MDU_FAST_MUL_EN
    if (!op[2]) return 2;
`endif
    return XLEN + 2;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    kill = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one op from IDLE, wait for the result, retire it.
  task automatic do_op(input logic [2:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, output logic [XLEN-1:0] res,
                       output int lat, output bit timeout);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    timeout = !out_valid;
    res = out_result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_result !== '0) begin n_fail++; $display("FAIL reset_out_result: got %h want 0", out_result); end
  endtask

  task automatic test_directed();
    logic [2:0]      t_op [11] = '{OP_MUL, OP_MULHU, OP_DIV, OP_REM, OP_REMU, OP_DIVU,
                                   OP_REM, OP_DIV, OP_REM, OP_MULH, OP_MULHSU};
    logic [XLEN-1:0] t_a  [11] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                                   32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                   32'hFFFF_FFFF};
    logic [XLEN-1:0] t_b  [11] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd0,
                                   32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                   32'hFFFF_FFFF};
    logic [XLEN-1:0] t_r  [11] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                   32'd1, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                                   32'h4000_0000, 32'hFFFF_FFFF};
    logic [XLEN-1:0] res;
    int lat;
    bit to;
    for (int i = 0; i < 11; i++) begin
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL directed_ready[%0d]: got %b want 1", i, in_ready); end
      do_op(t_op[i], t_a[i], t_b[i], res, lat, to);
      n_cmp++;
      if (to) begin n_fail++; $display("FAIL directed_timeout[%0d]: no out_valid within 200 cycles", i); end
      else if (res !== t_r[i]) begin n_fail++; $display("FAIL directed_result[%0d] op=%0d: got %h want %h", i, t_op[i], res, t_r[i]); end
      n_cmp++; if (lat != exp_lat(t_op[i], t_a[i], t_b[i])) begin
        n_fail++; $display("FAIL directed_latency[%0d] op=%0d: got %0d want %0d", i, t_op[i], lat, exp_lat(t_op[i], t_a[i], t_b[i]));
      end
    end
  endtask

  task automatic test_hold();
    int n;
    bit bad_v, bad_r, bad_rdy;
    in_valid = 1'b1; in_op = OP_MUL; in_a = 32'd3; in_b = 32'd5; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_wait: got out_valid %b want 1", out_valid); end
    bad_v = 0; bad_r = 0; bad_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1) bad_v = 1;
      if (out_result !== 32'd15) bad_r = 1;
      if (in_ready !== 1'b0) bad_rdy = 1;
    end
    n_cmp++; if (bad_v) begin n_fail++; $display("FAIL hold_valid: got drop want held 1"); end
    n_cmp++; if (bad_r) begin n_fail++; $display("FAIL hold_result: got %h want %h", out_result, 32'd15); end
    n_cmp++; if (bad_rdy) begin n_fail++; $display("FAIL hold_in_ready: got 1 want 0 while held"); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_retire_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_retire_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_kill();
    bit seen;
    logic [XLEN-1:0] res;
    int lat;
    bit to;
    // kill in CALC cycle 5
    in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd1000; in_b = 32'd7; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL kill_calc_ready: got %b want 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL kill_calc_valid: got out_valid 1 want never"); end
    do_op(OP_MUL, 32'd3, 32'd4, res, lat, to);
    n_cmp++; if (to || res !== 32'd12) begin n_fail++; $display("FAIL kill_followup: got %h (timeout %0d) want %h", res, to, 32'd12); end

    // kill together with in_valid in IDLE: not accepted
    in_valid = 1'b1; kill = 1'b1; in_op = OP_DIVU; in_a = 32'd9; in_b = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL kill_idle: got in_ready %b out_valid %b want 1 0", in_ready, out_valid);
    end

    // kill while a result is held in DONE
    in_valid = 1'b1; in_op = OP_REM; in_a = 32'd5; in_b = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL kill_done_pre: got %b want 1", out_valid); end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL kill_done: got out_valid %b in_ready %b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_rst_mid();
    in_valid = 1'b1; in_op = OP_MULHU; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (out_result !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid: got result %h valid %b ready %b want 0 0 1", out_result, out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic [2:0]      op;
    logic [XLEN-1:0] a, b, res, exp;
    int lat;
    bit to;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       begin a = $urandom; b = '0; end
        1:       begin a = MIN_INT; b = '1; end
        2:       begin a = $urandom_range(0, 100); b = $urandom_range(1, 10); end
        3:       begin a = -$urandom_range(0, 100); b = $urandom_range(1, 10); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      exp_q.push_back(ref_mdu(op, a, b));
      do_op(op, a, b, res, lat, to);
      exp = exp_q.pop_front();
      n_cmp++;
      if (to) begin n_fail++; $display("FAIL random_timeout[%0d] op=%0d", i, op); end
      else if (res !== exp) begin n_fail++; $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, res, exp); end
      n_cmp++; if (lat != exp_lat(op, a, b)) begin
        n_fail++; $display("FAIL random_latency[%0d] op=%0d: got %0d want %0d", i, op, lat, exp_lat(op, a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc [3];
    int idx, got;
    bit accepting;
    logic [XLEN-1:0] exp;
    idx = 0; got = 0;
    in_op = OP_DIVU; in_a = $urandom; in_b = $urandom_range(1, 1000);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 300 && got < 3; c++) begin
      if (out_valid) begin
        exp = exp_q.pop_front();
        n_cmp++; if (out_result !== exp) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h want %h", got, out_result, exp); end
        got++;
      end
      accepting = in_valid && in_ready;
      if (accepting) begin
        acc_cyc[idx] = cyc;
        exp_q.push_back(ref_mdu(in_op, in_a, in_b));
      end
      @(posedge clk); #1;
      if (accepting) begin
        idx++;
        if (idx < 3) begin in_a = $urandom; in_b = $urandom_range(1, 1000); end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (got != 3) begin n_fail++; $display("FAIL b2b_count: got %0d results want 3", got); end
    else begin
      n_cmp++; if (acc_cyc[1] - acc_cyc[0] != XLEN + 3) begin
        n_fail++; $display("FAIL b2b_gap0: got %0d want %0d", acc_cyc[1] - acc_cyc[0], XLEN + 3);
      end
      n_cmp++; if (acc_cyc[2] - acc_cyc[1] != XLEN + 3) begin
        n_fail++; $display("FAIL b2b_gap1: got %0d want %0d", acc_cyc[2] - acc_cyc[1], XLEN + 3);
      end
    end
    exp_q.delete();
  endtask

`ifdef MDU_FAST_MUL_EN
  task automatic test_fast_mul();
    logic [XLEN-1:0] res;
    int lat;
    bit to;
    do_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, res, lat, to);
    n_cmp++; if (to || res !== 32'h4000_0000 || lat != 2) begin
      n_fail++; $display("FAIL fast_mulh: got %h lat %0d want %h lat 2", res, lat, 32'h4000_0000);
    end
    do_op(OP_DIV, 32'd100, 32'd7, res, lat, to);
    n_cmp++; if (to || res !== 32'd14 || lat != 34) begin
      n_fail++; $display("FAIL fast_div: got %h lat %0d want %h lat 34", res, lat, 32'd14);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_kill();
    test_rst_mid();
    test_random();
    test_back_to_back();
`ifdef MDU_FAST_MUL_EN
    test_fast_mul();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
